// File: rtl/led_sequencer.sv
// LED pattern sequencer: queues {pattern, hold} entries in a 4-deep FIFO and
// shows each one for hold*CLK_PER_TICK cycles, with a 16-step PWM brightness.
module led_sequencer #(
  parameter int unsigned CLK_PER_TICK = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pat_valid,
  output logic       pat_ready,
  input  logic [3:0] pat_data,
  input  logic [7:0] pat_hold,
  input  logic [3:0] duty,
  output logic [3:0] led,
  output logic       busy
);

  localparam logic [15:0] TickLast = 16'(CLK_PER_TICK - 1);

  typedef enum logic {StIdle, StShow} state_t;

  state_t      state_q, state_d;
  logic [3:0]  fifo_pat  [4];
  logic [7:0]  fifo_hold [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic [15:0] presc_q, presc_d;
  logic [8:0]  hold_q, hold_d;
  logic [3:0]  cur_pat_q, cur_pat_d;
  logic [3:0]  pwm_cnt_q;
  logic [3:0]  led_q, led_d;

  logic       push, pop, tick, show_end, pwm_on;
  logic [3:0] head_pat;
  logic [8:0] head_hold;

  assign pat_ready = (count_q != 3'd4);
  assign busy      = (state_q == StShow) || (count_q != 3'd0);
  assign led       = led_q;

  assign push      = pat_valid && pat_ready;
  assign tick      = (state_q == StShow) && (presc_q == TickLast);
  assign show_end  = tick && (hold_q == 9'd1);
  assign pop       = (count_q != 3'd0) && ((state_q == StIdle) || show_end);
  assign head_pat  = fifo_pat[rd_ptr_q];
  // A stored hold of zero stands for a full 256 ticks.
  assign head_hold = (fifo_hold[rd_ptr_q] == 8'd0) ? 9'd256 : {1'b0, fifo_hold[rd_ptr_q]};
  assign pwm_on    = (duty == 4'hf) || (pwm_cnt_q < duty);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 3'd1;
    end else if (pop && !push) begin
      count_d = count_q - 3'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_pat_d = cur_pat_q;
    hold_d    = hold_q;
    presc_d   = presc_q;
    case (state_q)
      StIdle: begin
        if (pop) begin
          state_d   = StShow;
          cur_pat_d = head_pat;
          hold_d    = head_hold;
          presc_d   = 16'd0;
        end
      end
      StShow: begin
        if (tick) begin
          presc_d = 16'd0;
          hold_d  = hold_q - 9'd1;
          if (show_end) begin
            if (pop) begin
              // Chain straight into the next entry so no dark cycle appears.
              cur_pat_d = head_pat;
              hold_d    = head_hold;
            end else begin
              state_d = StIdle;
            end
          end
        end else begin
          presc_d = presc_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    led_d = 4'b0000;
    if (state_q == StShow) begin
      led_d = cur_pat_q & {4{pwm_on}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      wr_ptr_q  <= 2'd0;
      rd_ptr_q  <= 2'd0;
      count_q   <= 3'd0;
      presc_q   <= 16'd0;
      hold_q    <= 9'd0;
      cur_pat_q <= 4'd0;
      pwm_cnt_q <= 4'd0;
      led_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      hold_q    <= hold_d;
      cur_pat_q <= cur_pat_d;
      pwm_cnt_q <= pwm_cnt_q + 4'd1;
      led_q     <= led_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      fifo_pat[wr_ptr_q]  <= pat_data;
      fifo_hold[wr_ptr_q] <= pat_hold;
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with CLK_PER_TICK=4; expectations are
// hand-derived cycle counts relative to the accepting clock edge.
module tb_led_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       pat_valid;
  logic       pat_ready;
  logic [3:0] pat_data;
  logic [7:0] pat_hold;
  logic [3:0] duty;
  logic [3:0] led;
  logic       busy;

  int checks = 0;
  int failures = 0;

  led_sequencer #(.CLK_PER_TICK(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .pat_valid (pat_valid),
    .pat_ready (pat_ready),
    .pat_data  (pat_data),
    .pat_hold  (pat_hold),
    .duty      (duty),
    .led       (led),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Advance past one rising edge; inputs driven and outputs sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [3:0] d, input logic [7:0] h);
    pat_valid = 1'b1;
    pat_data  = d;
    pat_hold  = h;
    step();
    pat_valid = 1'b0;
    pat_data  = 4'd0;
    pat_hold  = 8'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++;
    if (led !== 4'b0000) begin
      failures++; $display("FAIL reset_led got=%b exp=0000", led);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy got=%b exp=0", busy);
    end
    checks++;
    if (pat_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready got=%b exp=1", pat_ready);
    end
  endtask

  task automatic test_single();
    duty = 4'hf;
    push_one(4'b1010, 8'd3);
    step();
    checks++;
    if (led !== 4'b0000 || busy !== 1'b1) begin
      failures++; $display("FAIL single_e1 led=%b busy=%b exp led=0000 busy=1", led, busy);
    end
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (led !== 4'b1010) begin
        failures++; $display("FAIL single_on cyc=%0d got=%b exp=1010", i, led);
      end
    end
    step();
    checks++;
    if (led !== 4'b0000 || busy !== 1'b0) begin
      failures++; $display("FAIL single_end led=%b busy=%b exp led=0000 busy=0", led, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    duty = 4'hf;
    step();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (pat_ready !== 1'b1) begin
        failures++; $display("FAIL b2b_ready k=%0d got=%b exp=1", k, pat_ready);
      end
      pat_valid = 1'b1;
      pat_data  = 4'(1 << k);
      pat_hold  = 8'd1;
      step();
    end
    pat_valid = 1'b0;
    // Now just past edge 3; entry k shows on edges 2+4k .. 5+4k.
    for (int c = 3; c <= 18; c++) begin
      if (c > 3) step();
      exp = ((c - 2) / 4 < 4) ? 4'(1 << ((c - 2) / 4)) : 4'b0000;
      checks++;
      if (led !== exp) begin
        failures++; $display("FAIL b2b_led edge=%0d got=%b exp=%b", c, led, exp);
      end
    end
  endtask

  task automatic test_full();
    logic [3:0] seq [6];
    logic [3:0] exp;
    logic       exp_rdy;
    seq[0] = 4'b1001; seq[1] = 4'b0001; seq[2] = 4'b0010;
    seq[3] = 4'b0100; seq[4] = 4'b1000; seq[5] = 4'b0011;
    duty = 4'hf;
    step();
    push_one(seq[0], 8'd10);
    for (int c = 1; c <= 62; c++) begin
      pat_valid = 1'b0;
      pat_data  = 4'hc;
      pat_hold  = 8'hee;
      if (c >= 2 && c <= 5) begin
        pat_valid = 1'b1; pat_data = seq[c - 1]; pat_hold = 8'd1;
      end else if (c >= 6 && c <= 42) begin
        pat_valid = 1'b1; pat_data = seq[5]; pat_hold = 8'd1;
      end
      step();
      if (c <= 44) begin
        exp_rdy = (c <= 4) || (c == 41);
        checks++;
        if (pat_ready !== exp_rdy) begin
          failures++; $display("FAIL full_ready edge=%0d got=%b exp=%b", c, pat_ready, exp_rdy);
        end
      end
      if (c == 1 || c == 62)      exp = 4'b0000;
      else if (c <= 41)           exp = seq[0];
      else                        exp = seq[1 + (c - 42) / 4];
      checks++;
      if (led !== exp) begin
        failures++; $display("FAIL full_led edge=%0d got=%b exp=%b", c, led, exp);
      end
    end
    pat_valid = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL full_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_pwm();
    int on_c, off_c, other_c;
    on_c = 0; off_c = 0; other_c = 0;
    duty = 4'd4;
    step();
    push_one(4'b1111, 8'd16);
    step();
    for (int i = 0; i < 64; i++) begin
      step();
      if (led === 4'b1111) on_c++;
      else if (led === 4'b0000) off_c++;
      else other_c++;
    end
    checks++;
    if (on_c != 16) begin
      failures++; $display("FAIL pwm_on_count got=%0d exp=16", on_c);
    end
    checks++;
    if (off_c != 48 || other_c != 0) begin
      failures++; $display("FAIL pwm_off_count off=%0d other=%0d exp off=48 other=0", off_c, other_c);
    end
    step();
    checks++;
    if (led !== 4'b0000 || busy !== 1'b0) begin
      failures++; $display("FAIL pwm_end led=%b busy=%b exp led=0000 busy=0", led, busy);
    end
    duty = 4'd0;
    on_c = 0;
    push_one(4'b1111, 8'd2);
    step();
    for (int i = 0; i < 8; i++) begin
      step();
      if (led !== 4'b0000) on_c++;
    end
    checks++;
    if (on_c != 0) begin
      failures++; $display("FAIL pwm_duty0 lit_cycles=%0d exp=0", on_c);
    end
    step();
  endtask

  task automatic test_hold0();
    int on_c;
    on_c = 0;
    duty = 4'hf;
    step();
    push_one(4'b0110, 8'd0);
    step();
    for (int c = 2; c <= 1026; c++) begin
      step();
      if (led === 4'b0110) on_c++;
      if (c == 2 || c == 1025) begin
        checks++;
        if (led !== 4'b0110) begin
          failures++; $display("FAIL hold0_edge edge=%0d got=%b exp=0110", c, led);
        end
      end
    end
    checks++;
    if (led !== 4'b0000) begin
      failures++; $display("FAIL hold0_end got=%b exp=0000", led);
    end
    checks++;
    if (on_c != 1024) begin
      failures++; $display("FAIL hold0_count got=%0d exp=1024", on_c);
    end
  endtask

  task automatic test_mid_reset();
    int bad;
    bad = 0;
    duty = 4'hf;
    step();
    push_one(4'b0001, 8'd5);
    push_one(4'b0010, 8'd5);
    push_one(4'b0100, 8'd5);
    step();
    step();
    checks++;
    if (led !== 4'b0001 || busy !== 1'b1) begin
      failures++; $display("FAIL mreset_pre led=%b busy=%b exp led=0001 busy=1", led, busy);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (led !== 4'b0000 || busy !== 1'b0 || pat_ready !== 1'b1) begin
      failures++;
      $display("FAIL mreset_post led=%b busy=%b ready=%b exp 0000/0/1", led, busy, pat_ready);
    end
    for (int i = 0; i < 40; i++) begin
      step();
      if (led !== 4'b0000 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL mreset_quiet bad_cycles=%0d exp=0", bad);
    end
  endtask

  initial begin
    reset     = 1'b1;
    pat_valid = 1'b0;
    pat_data  = 4'd0;
    pat_hold  = 8'd0;
    duty      = 4'hf;
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_pwm();
    test_hold0();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
